// File: rtl/fpu_cmd_issuer_if.sv
// rtl/fpu_cmd_issuer_if.sv - host command, FPU and response signal bundle for fpu_cmd_issuer
interface fpu_cmd_issuer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [1:0] cmd_op;
  logic       cmd_rnd;
  logic       fp_start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [1:0] fp_operation;
  logic       fp_round_mode;
  logic       fp_done;
  logic [7:0] op_result;
  logic       fp_is_exception;
  logic [1:0] fp_exception;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_exc;
  logic [1:0] rsp_exc_code;
  logic       rsp_timeout;
  logic       busy;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_rnd,
    input  fp_done, op_result, fp_is_exception, fp_exception, rsp_ready,
    output cmd_ready, fp_start, op_a, op_b, fp_operation, fp_round_mode,
    output rsp_valid, rsp_result, rsp_exc, rsp_exc_code, rsp_timeout, busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_rnd,
    output fp_done, op_result, fp_is_exception, fp_exception, rsp_ready,
    input  cmd_ready, fp_start, op_a, op_b, fp_operation, fp_round_mode,
    input  rsp_valid, rsp_result, rsp_exc, rsp_exc_code, rsp_timeout, busy
  );
endinterface

// File: rtl/fpu_cmd_issuer.sv
// rtl/fpu_cmd_issuer.sv - queues FPU commands, issues them one at a time and returns responses
module fpu_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input logic             clk,
  input logic             rst,
  fpu_cmd_issuer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic       rnd;
    logic [1:0] op;
    logic [7:0] b;
    logic [7:0] a;
  } cmd_t;

  state_t        state, state_nx;
  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  logic          push, pop, fifo_empty, cap_done, cap_timeout;

  cmd_t          op_q;
  logic [7:0]    rsp_result_q;
  logic          rsp_exc_q, rsp_timeout_q;
  logic [1:0]    rsp_code_q;

  assign fifo_empty    = (count == '0);
  // Ready is forced low during reset so nothing is accepted on the reset edge.
  assign bus.cmd_ready = ~rst & (count != FULL);
  assign push          = bus.cmd_valid & bus.cmd_ready;
  assign head          = mem[rd_ptr];

  assign bus.fp_start      = (state == S_ISSUE);
  assign bus.rsp_valid     = (state == S_RESP);
  assign bus.busy          = ~fifo_empty | (state != S_IDLE);
  assign bus.op_a          = op_q.a;
  assign bus.op_b          = op_q.b;
  assign bus.fp_operation  = op_q.op;
  assign bus.fp_round_mode = op_q.rnd;
  assign bus.rsp_result    = rsp_result_q;
  assign bus.rsp_exc       = rsp_exc_q;
  assign bus.rsp_exc_code  = rsp_code_q;
  assign bus.rsp_timeout   = rsp_timeout_q;

  always_comb begin
    state_nx    = state;
    pop         = 1'b0;
    cap_done    = 1'b0;
    cap_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        // A completion on the last allowed cycle takes priority over the timeout.
        if (bus.fp_done) begin
          cap_done = 1'b1;
          state_nx = S_RESP;
        end else if (timer == TMAX) begin
          cap_timeout = 1'b1;
          state_nx    = S_RESP;
        end
      end
      default: begin
        if (bus.rsp_ready) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            state_nx = S_ISSUE;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.cmd_rnd, bus.cmd_op, bus.cmd_b, bus.cmd_a};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      timer         <= '0;
      op_q          <= '0;
      rsp_result_q  <= '0;
      rsp_exc_q     <= 1'b0;
      rsp_code_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        op_q   <= head;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (state == S_ISSUE)     timer <= '0;
      else if (state == S_WAIT) timer <= timer + TW'(1);
      if (cap_done) begin
        rsp_result_q  <= bus.op_result;
        rsp_exc_q     <= bus.fp_is_exception;
        rsp_code_q    <= bus.fp_exception;
        rsp_timeout_q <= 1'b0;
      end else if (cap_timeout) begin
        rsp_result_q  <= 8'h00;
        rsp_exc_q     <= 1'b1;
        rsp_code_q    <= 2'b11;
        rsp_timeout_q <= 1'b1;
      end
    end
  end
endmodule
